// File: rtl/serial_sub_ctrl.sv
// Purpose : bit-serial WIDTH-bit subtractor, D = A - B plus final borrow, one bit per clock
//           through a single full-subtractor cell built from two half subtractors.
// Latency : start accepted at edge E0, D/Bout valid with done at E(WIDTH), IDLE again at E(WIDTH+1).
// Backpres: none; start is only honoured in IDLE, starts seen in RUN/DONE are dropped.
// Ports   : clk, rst (sync, active-high), start, A/B operands (captured on accept),
//           busy (RUN), done (1-cycle pulse), D difference mod 2^WIDTH, Bout = (A < B).
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  // full-subtractor cell on the current LSBs
  logic             hs1_d;
  logic             hs1_b;
  logic             hs2_b;
  logic             d_bit;
  logic             brw_next;
  logic [WIDTH-1:0] r_next;
  logic             last_bit;

  always_comb begin
    // first half subtractor: a - b
    hs1_d    = a_sh[0] ^ b_sh[0];
    hs1_b    = ~a_sh[0] & b_sh[0];
    // second half subtractor: (a - b) - borrow_in
    d_bit    = hs1_d ^ brw;
    hs2_b    = ~hs1_d & brw;
    brw_next = hs1_b | hs2_b;
    // result bits arrive LSB first, so they enter at the top and walk down;
    // after WIDTH shifts the first bit sits at bit 0
    r_next   = {d_bit, r_sh[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            r_sh  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy <= 1'b0;
          end
        end

        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh <= r_next;
          brw  <= brw_next;
          cnt  <= cnt + CW'(1);
          if (last_bit) begin
            // result includes the bit produced this cycle
            D     <= r_next;
            Bout  <= brw_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          // single-cycle pulse; start is deliberately not looked at here
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
